// File: rtl/valet_if.sv
// ---------------------------------------------------------------------------
// valet_if: bundle of signals between the front desk, valet_dispatcher and
// the parking-lot CAM.
//   master : dispatcher view (takes requests, drives responses and CAM strobes)
//   slave  : environment view (front desk + CAM + statistics sink)
// Groups: req_* (front desk -> dispatcher), rsp_* (dispatcher -> front desk),
//         cam_* (dispatcher <-> CAM), stat_* (statistics outputs).
// ---------------------------------------------------------------------------
interface valet_if #(
    parameter int DATA_WIDTH = 16,
    parameter int STAT_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_op;
    logic [DATA_WIDTH-1:0] req_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_op;
    logic [1:0]            rsp_status;
    logic [DATA_WIDTH-1:0] rsp_tag;

    logic                  cam_write_enable;
    logic                  cam_read_enable;
    logic [DATA_WIDTH-1:0] cam_data_in;
    logic [DATA_WIDTH-1:0] cam_match_tag;
    logic [DATA_WIDTH-1:0] cam_data_out;
    logic                  cam_full;
    logic                  cam_empty;
    logic                  cam_match_found;
    logic                  cam_cooldown_active;

    logic [STAT_WIDTH-1:0] stat_parks;
    logic [STAT_WIDTH-1:0] stat_retrieves;
    logic [STAT_WIDTH-1:0] stat_errors;

    modport master (
        input  req_valid, req_op, req_tag, rsp_ready,
               cam_data_out, cam_full, cam_empty, cam_match_found, cam_cooldown_active,
        output req_ready, rsp_valid, rsp_op, rsp_status, rsp_tag,
               cam_write_enable, cam_read_enable, cam_data_in, cam_match_tag,
               stat_parks, stat_retrieves, stat_errors
    );

    modport slave (
        output req_valid, req_op, req_tag, rsp_ready,
               cam_data_out, cam_full, cam_empty, cam_match_found, cam_cooldown_active,
        input  req_ready, rsp_valid, rsp_op, rsp_status, rsp_tag,
               cam_write_enable, cam_read_enable, cam_data_in, cam_match_tag,
               stat_parks, stat_retrieves, stat_errors
    );
endinterface

// File: rtl/valet_dispatcher.sv
// ---------------------------------------------------------------------------
// valet_dispatcher: initiator side of the parking-lot CAM interface.
// Queues park/retrieve requests in a small FIFO, issues them one at a time to
// the CAM honouring cooldown/full/empty, and returns one status-tagged
// response per request (00=OK 01=FULL 10=MISS 11=TIMEOUT).
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : valet_if.master (req_*, rsp_*, cam_*, stat_*)
// Optional feature: define VALET_STATS_EN for saturating statistics counters;
// otherwise stat_* are tied to 0.
// ---------------------------------------------------------------------------
module valet_dispatcher #(
    parameter int DATA_WIDTH     = 16,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STAT_WIDTH     = 16
) (
    input  logic    clk,
    input  logic    reset,
    valet_if.master bus
);
    localparam int AW = $clog2(REQ_FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_FULL    = 2'b01;
    localparam logic [1:0] ST_MISS    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state, w_next;
    logic                  r_live;
    logic [DATA_WIDTH:0]   r_mem [REQ_FIFO_DEPTH];   // {op, tag}
    logic [AW:0]           r_wptr, r_rptr;            // extra MSB separates full from empty
    logic [TW-1:0]         r_timer;
    logic                  r_hold_op;
    logic [DATA_WIDTH-1:0] r_hold_tag;
    logic                  r_rsp_op;
    logic [1:0]            r_rsp_status;
    logic [DATA_WIDTH-1:0] r_rsp_tag;

    logic                  w_full, w_empty, w_push, w_pop;
    logic                  w_load;
    logic [1:0]            w_status;
    logic [DATA_WIDTH-1:0] w_rtag;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = bus.req_valid && bus.req_ready;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    // r_live keeps req_ready low while reset is held.
    assign bus.req_ready = r_live && !w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_live <= 1'b0;
        else       r_live <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {bus.req_op, bus.req_tag};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_hold_op  <= 1'b0;
            r_hold_tag <= '0;
            r_timer    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr                  <= r_rptr + 1'b1;
                {r_hold_op, r_hold_tag} <= r_mem[r_rptr[AW-1:0]];
                r_timer                 <= '0;
            end else if (r_state == S_ISSUE && bus.cam_cooldown_active) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state, plus the response that gets latched on entry to RESP
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_status = ST_OK;
        w_rtag   = r_hold_tag;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_ISSUE;
            S_ISSUE: begin
                // Cooldown has priority: nothing is decided until it clears.
                if (bus.cam_cooldown_active) begin
                    if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        w_next   = S_RESP;
                        w_load   = 1'b1;
                        w_status = ST_TIMEOUT;
                    end
                end else if (!r_hold_op) begin
                    w_next   = S_RESP;
                    w_load   = 1'b1;
                    w_status = bus.cam_full ? ST_FULL : ST_OK;
                end else if (bus.cam_empty) begin
                    w_next   = S_RESP;
                    w_load   = 1'b1;
                    w_status = ST_MISS;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_RESP;
                w_load = 1'b1;
                if (bus.cam_match_found) begin
                    w_status = ST_OK;
                    w_rtag   = bus.cam_data_out;
                end else begin
                    w_status = ST_MISS;
                end
            end
            S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs. Strobes are decoded from ISSUE only, so they drop the
    // instant reset forces the state back to IDLE.
    always_comb begin
        bus.cam_write_enable = (r_state == S_ISSUE) && !bus.cam_cooldown_active &&
                               !r_hold_op && !bus.cam_full;
        bus.cam_read_enable  = (r_state == S_ISSUE) && !bus.cam_cooldown_active &&
                               r_hold_op && !bus.cam_empty;
        bus.rsp_valid        = (r_state == S_RESP);
    end

    assign bus.cam_data_in   = r_hold_tag;
    assign bus.cam_match_tag = r_hold_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_op     <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_tag    <= '0;
        end else if (w_load) begin
            r_rsp_op     <= r_hold_op;
            r_rsp_status <= w_status;
            r_rsp_tag    <= w_rtag;
        end
    end

    assign bus.rsp_op     = r_rsp_op;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_tag    = r_rsp_tag;

`ifdef VALET_STATS_EN
    logic                  w_rsp_hs;
    logic [STAT_WIDTH-1:0] r_parks, r_rets, r_errs;

    assign w_rsp_hs = bus.rsp_valid && bus.rsp_ready;

    // Counters saturate at all-ones rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parks <= '0;
            r_rets  <= '0;
            r_errs  <= '0;
        end else if (w_rsp_hs) begin
            if (r_rsp_status != ST_OK) begin
                if (!(&r_errs)) r_errs <= r_errs + 1'b1;
            end else if (!r_rsp_op) begin
                if (!(&r_parks)) r_parks <= r_parks + 1'b1;
            end else begin
                if (!(&r_rets)) r_rets <= r_rets + 1'b1;
            end
        end
    end

    assign bus.stat_parks     = r_parks;
    assign bus.stat_retrieves = r_rets;
    assign bus.stat_errors    = r_errs;
`else
    assign bus.stat_parks     = '0;
    assign bus.stat_retrieves = '0;
    assign bus.stat_errors    = '0;
`endif

endmodule

// File: tb/tb_valet_dispatcher.sv
module tb_valet_dispatcher;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    valet_if #(.DATA_WIDTH(16), .STAT_WIDTH(16)) bus ();

    valet_dispatcher #(
        .DATA_WIDTH(16), .REQ_FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .STAT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        op;
        logic [1:0]  st;
        logic [15:0] tag;
    } exp_t;

    // Strobe monitor, sampled mid-cycle.
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [15:0] last_wr = '0, last_rd = '0;
    always @(negedge clk) begin
        if (bus.cam_write_enable) begin wr_cnt <= wr_cnt + 1; last_wr <= bus.cam_data_in; end
        if (bus.cam_read_enable)  begin rd_cnt <= rd_cnt + 1; last_rd <= bus.cam_match_tag; end
        if (bus.cam_write_enable && bus.cam_read_enable) both_cnt <= both_cnt + 1;
    end

    // Expected response from the behavioural rules, CAM state held constant.
    function automatic exp_t ref_model(input logic op, input logic [15:0] tag,
                                       input logic full, input logic empty,
                                       input logic match, input logic [15:0] dout);
        exp_t e;
        e.op = op; e.tag = tag;
        if (!op)        e.st = full ? 2'b01 : 2'b00;
        else if (empty) e.st = 2'b10;
        else if (match) begin e.st = 2'b00; e.tag = dout; end
        else            e.st = 2'b10;
        return e;
    endfunction

    task automatic cam_idle();
        bus.cam_full = 0; bus.cam_empty = 0; bus.cam_match_found = 0;
        bus.cam_cooldown_active = 0; bus.cam_data_out = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_req(input logic op, input logic [15:0] tag, output bit ok);
        bit acc;
        ok = 0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_tag = tag;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); acc = bus.req_ready;
            @(posedge clk); #1; ok = acc;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc, output bit ok);
        ok = 0; cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin cyc = i; ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if ({bus.cam_write_enable, bus.cam_read_enable} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {bus.cam_write_enable, bus.cam_read_enable}); end
        n_checks++; if ({bus.stat_parks, bus.stat_retrieves, bus.stat_errors} !== 48'h0) begin n_fail++; $display("FAIL reset_stats: got %h want 0", {bus.stat_parks, bus.stat_retrieves, bus.stat_errors}); end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_park();
        int cyc; bit ok; int w0, r0;
        cam_idle(); bus.rsp_ready = 1; w0 = wr_cnt; r0 = rd_cnt;
        push_req(1'b0, 16'h00A5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL park_accept: got timeout want accept"); end
        wait_rsp(cyc, ok);
        n_checks++; if (!ok || cyc != 3) begin n_fail++; $display("FAIL park_latency: got %0d want 3", cyc); end
        n_checks++; if ({bus.rsp_op, bus.rsp_status, bus.rsp_tag} !== {1'b0, 2'b00, 16'h00A5}) begin n_fail++; $display("FAIL park_rsp: got op=%b st=%b tag=%h want 0/00/00a5", bus.rsp_op, bus.rsp_status, bus.rsp_tag); end
        n_checks++; if (wr_cnt - w0 != 1 || rd_cnt != r0 || last_wr !== 16'h00A5) begin n_fail++; $display("FAIL park_strobe: got wr=%0d rd=%0d data=%h want 1/0/00a5", wr_cnt - w0, rd_cnt - r0, last_wr); end
        @(posedge clk); #1;
    endtask

    task automatic test_retrieve();
        int cyc; bit ok; int w0, r0;
        cam_idle(); bus.cam_match_found = 1; bus.cam_data_out = 16'h00A5;
        bus.rsp_ready = 1; w0 = wr_cnt; r0 = rd_cnt;
        push_req(1'b1, 16'h00A5, ok);
        wait_rsp(cyc, ok);
        n_checks++; if (!ok || cyc != 4) begin n_fail++; $display("FAIL retrieve_latency: got %0d want 4", cyc); end
        n_checks++; if ({bus.rsp_op, bus.rsp_status, bus.rsp_tag} !== {1'b1, 2'b00, 16'h00A5}) begin n_fail++; $display("FAIL retrieve_rsp: got op=%b st=%b tag=%h want 1/00/00a5", bus.rsp_op, bus.rsp_status, bus.rsp_tag); end
        n_checks++; if (rd_cnt - r0 != 1 || wr_cnt != w0 || last_rd !== 16'h00A5) begin n_fail++; $display("FAIL retrieve_strobe: got rd=%0d wr=%0d tag=%h want 1/0/00a5", rd_cnt - r0, wr_cnt - w0, last_rd); end
        @(posedge clk); #1;
        cam_idle();
    endtask

    task automatic test_retrieve_empty();
        int cyc; bit ok; int w0, r0;
        cam_idle(); bus.cam_empty = 1; bus.rsp_ready = 1; w0 = wr_cnt; r0 = rd_cnt;
        push_req(1'b1, 16'h1234, ok);
        wait_rsp(cyc, ok);
        n_checks++; if (!ok || {bus.rsp_op, bus.rsp_status, bus.rsp_tag} !== {1'b1, 2'b10, 16'h1234}) begin n_fail++; $display("FAIL empty_rsp: got op=%b st=%b tag=%h want 1/10/1234", bus.rsp_op, bus.rsp_status, bus.rsp_tag); end
        n_checks++; if (rd_cnt != r0 || wr_cnt != w0) begin n_fail++; $display("FAIL empty_strobe: got rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_cnt - w0); end
        @(posedge clk); #1;
        cam_idle();
    endtask

    task automatic test_timeout();
        int cyc; bit ok; int w0, r0;
        cam_idle(); bus.cam_cooldown_active = 1; bus.rsp_ready = 1; w0 = wr_cnt; r0 = rd_cnt;
        push_req(1'b0, 16'h0BAD, ok);
        wait_rsp(cyc, ok);
        // 1 IDLE cycle + 16 ISSUE cycles, response on the next.
        n_checks++; if (!ok || cyc != 18) begin n_fail++; $display("FAIL timeout_latency: got %0d want 18", cyc); end
        n_checks++; if ({bus.rsp_op, bus.rsp_status, bus.rsp_tag} !== {1'b0, 2'b11, 16'h0BAD}) begin n_fail++; $display("FAIL timeout_rsp: got op=%b st=%b tag=%h want 0/11/0bad", bus.rsp_op, bus.rsp_status, bus.rsp_tag); end
        n_checks++; if (rd_cnt != r0 || wr_cnt != w0) begin n_fail++; $display("FAIL timeout_strobe: got rd=%0d wr=%0d want 0/0", rd_cnt - r0, wr_cnt - w0); end
        @(posedge clk); #1;
        cam_idle();
    endtask

    task automatic test_fifo_fill();
        int acc_n; bit acc, ok; int cyc;
        exp_t q[$]; exp_t e;
        cam_idle(); bus.cam_empty = 1; bus.rsp_ready = 0; acc_n = 0;
        bus.req_valid = 1;
        for (int c = 0; c < 20; c++) begin
            bus.req_op = acc_n[0]; bus.req_tag = 16'h0100 + 16'(acc_n);
            @(negedge clk); acc = bus.req_ready;
            @(posedge clk); #1;
            if (acc) begin
                q.push_back(ref_model(bus.req_op, bus.req_tag, 1'b0, 1'b1, 1'b0, 16'h0));
                acc_n++;
            end
        end
        bus.req_valid = 0;
        n_checks++; if (acc_n != 5) begin n_fail++; $display("FAIL fill_count: got %0d want 5", acc_n); end
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", bus.req_ready); end
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            wait_rsp(cyc, ok);
            n_checks++; if (!ok || {bus.rsp_op, bus.rsp_status, bus.rsp_tag} !== e) begin n_fail++; $display("FAIL fill_order: got %b/%b/%h want %b/%b/%h", bus.rsp_op, bus.rsp_status, bus.rsp_tag, e.op, e.st, e.tag); end
            @(posedge clk); #1;
        end
        cam_idle();
    endtask

    task automatic test_reset_mid();
        bit ok; int seen, w0, r0;
        cam_idle(); bus.cam_cooldown_active = 1; bus.rsp_ready = 1;
        push_req(1'b0, 16'h7777, ok);
        push_req(1'b0, 16'h1111, ok);
        push_req(1'b1, 16'h2222, ok);
        repeat (3) begin @(posedge clk); #1; end
        bus.cam_cooldown_active = 0;
        #1;
        n_checks++; if (bus.cam_write_enable !== 1'b1 || bus.cam_data_in !== 16'h7777) begin n_fail++; $display("FAIL mid_strobe_pre: got we=%b data=%h want 1/7777", bus.cam_write_enable, bus.cam_data_in); end
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.cam_write_enable, bus.cam_read_enable, bus.rsp_valid, bus.req_ready} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_outputs: got %b want 0000", {bus.cam_write_enable, bus.cam_read_enable, bus.rsp_valid, bus.req_ready}); end
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        w0 = wr_cnt; r0 = rd_cnt; seen = 0;
        for (int c = 0; c < 15; c++) begin @(negedge clk); if (bus.rsp_valid) seen++; end
        n_checks++; if (seen != 0 || wr_cnt != w0 || rd_cnt != r0) begin n_fail++; $display("FAIL mid_dropped: got rsp=%0d wr=%0d rd=%0d want 0/0/0", seen, wr_cnt - w0, rd_cnt - r0); end
        @(posedge clk); #1;
    endtask

    task automatic test_stats();
        int cyc; bit ok;
        do_reset(); cam_idle(); bus.rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            bus.cam_empty = (k == 3);
            push_req(k == 3, 16'h0300 + 16'(k), ok);
            wait_rsp(cyc, ok);
            @(posedge clk); #1;
        end
        @(negedge clk);
`ifdef VALET_STATS_EN
        n_checks++; if ({bus.stat_parks, bus.stat_retrieves, bus.stat_errors} !== {16'd3, 16'd0, 16'd1}) begin n_fail++; $display("FAIL stats: got %0d/%0d/%0d want 3/0/1", bus.stat_parks, bus.stat_retrieves, bus.stat_errors); end
`else
        n_checks++; if ({bus.stat_parks, bus.stat_retrieves, bus.stat_errors} !== 48'h0) begin n_fail++; $display("FAIL stats_off: got %0d/%0d/%0d want 0/0/0", bus.stat_parks, bus.stat_retrieves, bus.stat_errors); end
`endif
        @(posedge clk); #1;
        cam_idle();
    endtask

    task automatic test_random();
        exp_t q[$]; exp_t e;
        int got, w0, r0, b0, ew, er, mp, mr, me;
        bit drv_ok;
        do_reset(); mp = 0; mr = 0; me = 0;
        for (int b = 0; b < 6; b++) begin
            bus.cam_full = 1'($urandom_range(0, 1)); bus.cam_empty = 1'($urandom_range(0, 1));
            bus.cam_match_found = 1'($urandom_range(0, 1)); bus.cam_data_out = 16'($urandom);
            bus.cam_cooldown_active = 0;
            w0 = wr_cnt; r0 = rd_cnt; b0 = both_cnt; ew = 0; er = 0; got = 0; drv_ok = 1;
            q.delete();
            fork
                begin
                    logic op; logic [15:0] tag; bit ok; exp_t x;
                    for (int k = 0; k < 10; k++) begin
                        op = 1'($urandom_range(0, 1)); tag = 16'($urandom);
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        push_req(op, tag, ok);
                        if (!ok) drv_ok = 0;
                        x = ref_model(op, tag, bus.cam_full, bus.cam_empty, bus.cam_match_found, bus.cam_data_out);
                        q.push_back(x);
                        if (!op && !bus.cam_full) ew++;
                        if (op && !bus.cam_empty) er++;
                        if (x.st != 2'b00) me++;
                        else if (!op) mp++;
                        else mr++;
                    end
                end
                begin
                    for (int c = 0; c < 1500 && got < 10; c++) begin
                        bus.rsp_ready = 1'($urandom_range(0, 1));
                        @(negedge clk);
                        if (bus.rsp_valid && bus.rsp_ready) begin
                            if (q.size() == 0) begin
                                n_checks++; n_fail++; $display("FAIL rand_unexpected_rsp: got tag %h want none", bus.rsp_tag);
                            end else begin
                                e = q.pop_front();
                                n_checks++; if ({bus.rsp_op, bus.rsp_status, bus.rsp_tag} !== e) begin n_fail++; $display("FAIL rand_rsp: got %b/%b/%h want %b/%b/%h", bus.rsp_op, bus.rsp_status, bus.rsp_tag, e.op, e.st, e.tag); end
                            end
                            got++;
                        end
                        @(posedge clk); #1;
                    end
                end
            join
            bus.rsp_ready = 1;
            n_checks++; if (got != 10 || !drv_ok) begin n_fail++; $display("FAIL rand_count: got %0d want 10", got); end
            n_checks++; if (wr_cnt - w0 != ew || rd_cnt - r0 != er || both_cnt != b0) begin n_fail++; $display("FAIL rand_strobes: got wr=%0d rd=%0d both=%0d want %0d/%0d/0", wr_cnt - w0, rd_cnt - r0, both_cnt - b0, ew, er); end
            @(negedge clk);
`ifdef VALET_STATS_EN
            n_checks++; if ({bus.stat_parks, bus.stat_retrieves, bus.stat_errors} !== {16'(mp), 16'(mr), 16'(me)}) begin n_fail++; $display("FAIL rand_stats: got %0d/%0d/%0d want %0d/%0d/%0d", bus.stat_parks, bus.stat_retrieves, bus.stat_errors, mp, mr, me); end
`else
            n_checks++; if ({bus.stat_parks, bus.stat_retrieves, bus.stat_errors} !== 48'h0) begin n_fail++; $display("FAIL rand_stats_off: got %0d/%0d/%0d want 0/0/0", bus.stat_parks, bus.stat_retrieves, bus.stat_errors); end
`endif
            @(posedge clk); #1;
        end
        cam_idle();
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 0; bus.req_op = 0; bus.req_tag = '0; bus.rsp_ready = 1;
        cam_idle();
        test_reset();
        test_park();
        test_retrieve();
        test_retrieve_empty();
        test_timeout();
        test_fifo_fill();
        test_reset_mid();
        test_stats();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
